// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs and MEM/WB outputs of the memory stage.
interface mem_stage_if;
   logic [31:0] EM_ALU, EM_RD2, EM_IR, EM_Pc4;
   logic        MemWrite;
   logic [1:0]  StoreType;
   logic [2:0]  LoadType;
   logic [31:0] MW_ALU, MW_MD, MW_IR, MW_Pc4;
   logic [4:0]  MW_IRRt, MW_IRRd;
   logic        AddrErr;
   modport master (
      output EM_ALU, EM_RD2, EM_IR, EM_Pc4, MemWrite, StoreType, LoadType,
      input  MW_ALU, MW_MD, MW_IR, MW_Pc4, MW_IRRt, MW_IRRd, AddrErr
   );
   modport slave (
      input  EM_ALU, EM_RD2, EM_IR, EM_Pc4, MemWrite, StoreType, LoadType,
      output MW_ALU, MW_MD, MW_IR, MW_Pc4, MW_IRRt, MW_IRRd, AddrErr
   );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: 4 KiB data memory with byte/half/word stores, extended loads and MEM/WB register.
// Define DM_DISPLAY_EN to log every committed memory write.
module mem_stage (
   input logic        clk,
   input logic        reset,
   mem_stage_if.slave bus
);
   logic [31:0] mem [1024];
   logic [9:0]  idx;
   logic [1:0]  a;
   logic [31:0] rd, sb_word, wdata, md;
   logic [15:0] hw;
   logic [7:0]  by;
   logic        mis, we;
   always_comb begin
      idx = bus.EM_ALU[11:2];
      a = bus.EM_ALU[1:0];
      rd = mem[idx];
      hw = a[1] ? rd[31:16] : rd[15:0];
      by = rd[{a, 3'b000} +: 8];
      md = bus.LoadType == 3'd1 ? {{16{hw[15]}}, hw} :
           bus.LoadType == 3'd2 ? {16'h0, hw} :
           bus.LoadType == 3'd3 ? {{24{by[7]}}, by} :
           bus.LoadType == 3'd4 ? {24'h0, by} : rd;
      sb_word = rd;
      sb_word[{a, 3'b000} +: 8] = bus.EM_RD2[7:0];
      wdata = bus.StoreType == 2'd0 ? bus.EM_RD2 :
              bus.StoreType == 2'd1 ? (a[1] ? {bus.EM_RD2[15:0], rd[15:0]} : {rd[31:16], bus.EM_RD2[15:0]}) :
              sb_word;
      mis = bus.MemWrite && ((bus.StoreType == 2'd0 && a != 2'd0) || (bus.StoreType == 2'd1 && a[0]));
      we = bus.MemWrite && bus.StoreType != 2'd3 && !mis;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
      end else if (we) begin
         mem[idx] <= wdata;
`ifdef DM_DISPLAY_EN
         $display("@%08h: *%08h <= %08h", bus.EM_Pc4 - 32'd4, {bus.EM_ALU[31:2], 2'b00}, wdata);
`endif
      end
   end
   // Pipeline register never stalls; loads are read before this edge's store lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.MW_ALU  <= '0;
         bus.MW_MD   <= '0;
         bus.MW_IR   <= '0;
         bus.MW_Pc4  <= '0;
         bus.MW_IRRt <= '0;
         bus.MW_IRRd <= '0;
         bus.AddrErr <= 1'b0;
      end else begin
         bus.MW_ALU  <= bus.EM_ALU;
         bus.MW_MD   <= md;
         bus.MW_IR   <= bus.EM_IR;
         bus.MW_Pc4  <= bus.EM_Pc4;
         bus.MW_IRRt <= bus.EM_IR[20:16];
         bus.MW_IRRd <= bus.EM_IR[15:11];
         bus.AddrErr <= mis;
      end
   end
endmodule
